// File: rtl/keypad_scan_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Purpose  : Matrix keypad scanner with press/release debounce and a key-code FIFO.
//            Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                            clk,
    input  logic                            nRST,
    input  logic [ROWS-1:0]                 RowIn,
    output logic [COLS-1:0]                 ColOut,
    output logic                            key_valid,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    input  logic                            key_read,
    output logic                            key_pressed,
    output logic                            overflow,
    output logic [1:0]                      scan_state
);

    localparam int c_ROW_W  = $clog2(ROWS);
    localparam int c_COL_W  = $clog2(COLS);
    localparam int c_CODE_W = $clog2(ROWS*COLS);
    localparam int c_SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(COLS - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_COL_W-1:0]     r_col;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_SCAN_W-1:0]    r_scan_cnt;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic                   r_key_pressed;

    logic [c_CODE_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_key_valid;
    logic [c_CODE_W-1:0]    r_key_code;
    logic                   r_overflow;

    logic [c_ROW_W-1:0]     w_low_row;
    logic                   w_any_low;
    logic                   w_row_bit;
    logic [c_COL_W-1:0]     w_col_next;
    logic [c_CODE_W-1:0]    w_code;
    logic                   w_accept;
    logic                   w_rep_push;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   w_drop;
    logic [c_CNT_W-1:0]     w_count_next;
    logic [c_PTR_W-1:0]     w_rd_next;
    logic [c_CODE_W-1:0]    w_head_next;

    // Lowest-index low row wins when several rows read low together.
    always_comb begin
        w_low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!RowIn[i]) begin
                w_low_row = c_ROW_W'(i);
            end
        end
    end

    assign w_any_low  = ~&RowIn;
    assign w_row_bit  = RowIn[r_row];
    assign w_col_next = (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
    assign w_code     = c_CODE_W'(int'(r_row) * COLS + int'(r_col));
    assign w_accept   = (r_state == ST_DB_PRESS) && !w_row_bit && (r_db_cnt == c_DB_LAST);
    assign w_push     = w_accept || w_rep_push;

`ifdef KEYPAD_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic [c_REP_W-1:0] w_rep_next;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; paused outside HELD.
    assign w_rep_next = r_rep_cnt + 1'b1;
    assign w_rep_push = (r_state == ST_HELD) && !w_row_bit &&
                        (r_rep_armed ? (w_rep_next == c_REP_W'(REPEAT_PERIOD))
                                     : (w_rep_next == c_REP_W'(REPEAT_DELAY)));

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_accept) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if ((r_state == ST_HELD) && !w_row_bit) begin
            if (w_rep_push) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt   <= w_rep_next;
            end
        end
    end
`else
    assign w_rep_push = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state       <= ST_SCAN;
            r_col         <= '0;
            r_row         <= '0;
            r_scan_cnt    <= '0;
            r_db_cnt      <= '0;
            r_key_pressed <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_scan_cnt == c_SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (w_any_low) begin
                            r_row    <= w_low_row;
                            r_db_cnt <= '0;
                            r_state  <= ST_DB_PRESS;
                        end else begin
                            r_col    <= w_col_next;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                ST_DB_PRESS: begin
                    if (w_row_bit) begin
                        r_db_cnt   <= '0;
                        r_scan_cnt <= '0;
                        r_col      <= w_col_next;
                        r_state    <= ST_SCAN;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_db_cnt      <= '0;
                        r_key_pressed <= 1'b1;
                        r_state       <= ST_HELD;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_row_bit) begin
                        r_db_cnt <= '0;
                        r_state  <= ST_DB_RELEASE;
                    end
                end
                ST_DB_RELEASE: begin
                    if (!w_row_bit) begin
                        r_db_cnt <= '0;
                        r_state  <= ST_HELD;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_db_cnt      <= '0;
                        r_key_pressed <= 1'b0;
                        r_scan_cnt    <= '0;
                        r_col         <= w_col_next;
                        r_state       <= ST_SCAN;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still takes a push then.
    assign w_pop        = key_read && r_key_valid;
    assign w_full       = (r_count == c_FULL);
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_count_next = r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);
    assign w_rd_next    = r_rd_ptr + c_PTR_W'(w_pop);

    // The incoming code becomes the head when nothing older survives this edge.
    always_comb begin
        w_head_next = '0;
        if (w_count_next != '0) begin
            if (r_count == c_CNT_W'(w_pop)) begin
                w_head_next = w_code;
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + c_PTR_W'(w_push_ok);
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_key_valid <= (w_count_next != '0);
            r_key_code  <= w_head_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ColOut      = ~(COLS'(1) << r_col);
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_pressed = r_key_pressed;
    assign overflow    = r_overflow;
    assign scan_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Purpose  : Directed self-checking bench for keypad_scan_fifo (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

    logic       clk;
    logic       nRST;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_read;
    logic       key_pressed;
    logic       overflow;
    logic [1:0] scan_state;

    logic       key_down;
    logic [1:0] key_row;
    logic [1:0] key_col;

    int n_checks;
    int n_fail;

    keypad_scan_fifo u_dut (
        .clk         (clk),
        .nRST        (nRST),
        .RowIn       (RowIn),
        .ColOut      (ColOut),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_read    (key_read),
        .key_pressed (key_pressed),
        .overflow    (overflow),
        .scan_state  (scan_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is strobed.
    assign RowIn = (key_down && !ColOut[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int i;
        i = 0;
        while (scan_state !== s && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(scan_state), 32'(s));
    endtask

    task automatic wait_pressed(input logic v, input string tag);
        int i;
        i = 0;
        while (key_pressed !== v && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(key_pressed), 32'(v));
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
    endtask

    task automatic press_release(input logic [1:0] row, input logic [1:0] col, input string tag);
        key_row  = row;
        key_col  = col;
        key_down = 1'b1;
        wait_pressed(1'b1, {tag, "_press"});
        key_down = 1'b0;
        wait_pressed(1'b0, {tag, "_release"});
    endtask

    task automatic read_code(input logic [3:0] exp, input string tag);
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_code"}, 32'(key_code), 32'(exp));
        key_read = 1'b1;
        tick(1);
        key_read = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, 32'(ColOut), 32'h0000_000E);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_code"}, 32'(key_code), 32'd0);
        check({tag, "_pressed"}, 32'(key_pressed), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_state"}, 32'(scan_state), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no end expected end of test");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        key_read = 1'b0;
        key_down = 1'b0;
        key_row  = 2'd0;
        key_col  = 2'd0;

        do_reset();
        check_reset_outputs("rst");

        // Key 6 (row 1, column 2): debounce, push latency, pop, release.
        key_row  = 2'd1;
        key_col  = 2'd2;
        key_down = 1'b1;
        wait_state(2'd1, "t1_dbpress");
        check("t1_col_frozen", 32'(ColOut), 32'h0000_000B);
        tick(7);
        check("t1_no_push_yet", 32'(key_valid), 32'd0);
        check("t1_still_db", 32'(scan_state), 32'd1);
        tick(1);
        check("t1_valid", 32'(key_valid), 32'd1);
        check("t1_code", 32'(key_code), 32'd6);
        check("t1_pressed", 32'(key_pressed), 32'd1);
        check("t1_held", 32'(scan_state), 32'd2);
        key_read = 1'b1;
        tick(1);
        key_read = 1'b0;
        check("t1_popped", 32'(key_valid), 32'd0);
        check("t1_code_empty", 32'(key_code), 32'd0);
        key_down = 1'b0;
        tick(1);
        check("t1_dbrelease", 32'(scan_state), 32'd3);
        wait_pressed(1'b0, "t1_release");
        check("t1_next_col", 32'(ColOut), 32'h0000_0007);
        check("t1_scan", 32'(scan_state), 32'd0);

        // Bounce: row 0 at column 1 low only 5 clocks.
        key_row  = 2'd0;
        key_col  = 2'd1;
        key_down = 1'b1;
        wait_state(2'd1, "t2_dbpress");
        tick(4);
        key_down = 1'b0;
        tick(1);
        check("t2_scan", 32'(scan_state), 32'd0);
        check("t2_no_push", 32'(key_valid), 32'd0);
        check("t2_not_pressed", 32'(key_pressed), 32'd0);
        check("t2_next_col", 32'(ColOut), 32'h0000_000B);

        // Five presses without reads: the fifth is dropped.
        press_release(2'd0, 2'd0, "t3_k0");
        press_release(2'd0, 2'd1, "t3_k1");
        press_release(2'd0, 2'd2, "t3_k2");
        press_release(2'd1, 2'd1, "t3_k5");
        check("t3_no_ovf_at_full", 32'(overflow), 32'd0);
        press_release(2'd2, 2'd2, "t3_k10");
        check("t3_ovf", 32'(overflow), 32'd1);
        read_code(4'd0, "t3_r0");
        read_code(4'd1, "t3_r1");
        read_code(4'd2, "t3_r2");
        read_code(4'd5, "t3_r3");
        check("t3_empty", 32'(key_valid), 32'd0);
        check("t3_empty_code", 32'(key_code), 32'd0);

        // Full FIFO with a pop on the accept edge of code 13.
        do_reset();
        press_release(2'd0, 2'd3, "t4_k3");
        press_release(2'd1, 2'd0, "t4_k4");
        press_release(2'd1, 2'd3, "t4_k7");
        press_release(2'd2, 2'd1, "t4_k9");
        check("t4_head", 32'(key_code), 32'd3);
        key_row  = 2'd3;
        key_col  = 2'd1;
        key_down = 1'b1;
        wait_state(2'd1, "t4_dbpress");
        tick(7);
        check("t4_pre_accept", 32'(key_pressed), 32'd0);
        key_read = 1'b1;
        tick(1);
        key_read = 1'b0;
        check("t4_accepted", 32'(key_pressed), 32'd1);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        key_down = 1'b0;
        wait_pressed(1'b0, "t4_release");
        read_code(4'd4, "t4_r4");
        read_code(4'd7, "t4_r7");
        read_code(4'd9, "t4_r9");
        read_code(4'd13, "t4_r13");
        check("t4_empty", 32'(key_valid), 32'd0);

        // Reset in the middle of a debounce with a non-empty FIFO.
        press_release(2'd1, 2'd1, "t5_k5");
        check("t5_stored", 32'(key_valid), 32'd1);
        key_row  = 2'd0;
        key_col  = 2'd0;
        key_down = 1'b1;
        wait_state(2'd1, "t5_dbpress");
        tick(4);
        nRST = 1'b0;
        tick(1);
        nRST     = 1'b1;
        key_down = 1'b0;
        check_reset_outputs("t5_rst");
        tick(1);
        check("t5_fifo_empty", 32'(key_valid), 32'd0);

        // Key 12 held 80 clocks after acceptance.
        do_reset();
        key_row  = 2'd3;
        key_col  = 2'd0;
        key_down = 1'b1;
        wait_pressed(1'b1, "t6_press");
        check("t6_code", 32'(key_code), 32'd12);
        tick(63);
        check("t6_ovf_mid", 32'(overflow), 32'd0);
        tick(17);
`ifdef KEYPAD_REPEAT_EN
        check("t6_ovf", 32'(overflow), 32'd1);
`else
        check("t6_ovf", 32'(overflow), 32'd0);
`endif
        key_down = 1'b0;
        wait_pressed(1'b0, "t6_release");
        read_code(4'd12, "t6_r0");
`ifdef KEYPAD_REPEAT_EN
        read_code(4'd12, "t6_r1");
        read_code(4'd12, "t6_r2");
        read_code(4'd12, "t6_r3");
`endif
        check("t6_empty", 32'(key_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad front end for the calculator datapath and the successor to the fixed 4x4 scanner.
- Drives active-low column strobes and samples active-low rows.
- Debounces press and release.
- Encodes each accepted key as index = row*COLS + col and queues codes in a FIFO.
- Downstream control pops codes with a key_read pulse, so presses are never lost while the consumer is busy.

Parameters:
ROWS, 4, number of keypad rows (2..8)
COLS, 4, number of keypad columns (2..8)
SCAN_CYCLES, 4, clocks each column stays strobed; RowIn sampled on the last of them
DEBOUNCE_CYCLES, 8, consecutive stable clocks required to accept a press or a release
FIFO_DEPTH, 4, key-code queue entries (power of two, >=2)
REPEAT_DELAY, 32, clocks held before first auto-repeat (KEYPAD_REPEAT_EN only)
REPEAT_PERIOD, 16, clocks between subsequent auto-repeats (KEYPAD_REPEAT_EN only)

Ports:
clk  in  1  system clock
nRST  in  1  reset; synchronous, active-low; one clock domain
RowIn  in  ROWS  keypad rows, active-low, already synchronised upstream
ColOut  out  COLS  column strobe, one-cold (exactly one bit low)
key_valid  out  1  FIFO non-empty
key_code  out  $clog2(ROWS*COLS)  FIFO head code; 0 when empty
key_read  in  1  pop request; honoured only when key_valid=1
key_pressed  out  1  debounced key-held level
overflow  out  1  sticky: a press was dropped because the FIFO was full
scan_state  out  2  FSM state (debug): 0 SCAN, 1 DB_PRESS, 2 HELD, 3 DB_RELEASE

Behaviour:
- Reset (nRST=0 at posedge) values: ColOut={ {COLS-1{1}},0 } (column 0 active), key_valid=0, key_code=0, key_pressed=0, overflow=0, scan_state=0.
  - Counters zero, FIFO emptied.
  - Reset mid-operation aborts any debounce; the FIFO content is discarded.
- SCAN state:
  - The active column advances every SCAN_CYCLES clocks: 0..COLS-1, then wraps to 0.
  - On the sample clock, if any RowIn bit is 0, latch the lowest-index low row plus the current column.
  - Go to DB_PRESS; ColOut freezes on that column.
- DB_PRESS:
  - The counter increments each clock the latched row reads 0.
  - Any clock it reads 1: clear the counter and return to SCAN, continuing at the next column.
  - When the count reaches DEBOUNCE_CYCLES: push the code, set key_pressed=1, go to HELD.
- HELD:
  - Latched row 1 -> go to DB_RELEASE with the counter cleared.
- DB_RELEASE:
  - The counter increments while the row reads 1; any 0 returns to HELD.
  - On reaching DEBOUNCE_CYCLES: key_pressed=0, go to SCAN at the next column.
- Other keys pressed while in DB_PRESS, HELD or DB_RELEASE are ignored (single-key rollover).
- FIFO rules:
  - key_valid and key_code are registered; a pushed code appears the clock after the push edge.
  - Push with FIFO full and no pop: drop the code, set overflow=1 (cleared only by reset).
  - Push and pop on the same clock when full: both succeed, overflow unchanged.
  - Push and pop on the same clock when empty: the pop is ignored; the code is stored.
  - key_read with key_valid=0 has no effect.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked in $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: in HELD, once the key has been held REPEAT_DELAY clocks since entering HELD, the same code is pushed again, then every REPEAT_PERIOD clocks until leaving HELD.
  - Repeat pushes follow the same full/overflow rules.
  - Entering DB_RELEASE pauses the repeat timer; returning to HELD resumes it.
- Undefined: each press produces exactly one push; REPEAT_* parameters are unused and the repeat timer is not synthesised.

Test Plan:
1. Defaults; hold RowIn=4'b1101 only while ColOut=4'b1011 and beyond -> DB_PRESS, push after 8 stable clocks; key_valid=1, key_code=6; one-clock key_read -> key_valid=0; release -> key_pressed=0 after 8 clocks, scanning resumes at column 3.
2. Bounce: row 0 low for 5 clocks at column 1, then high -> no push, key_valid stays 0, scan_state returns to 0.
3. Five presses of codes 0,1,2,5,10 with no key_read -> overflow=1. Four reads return 0,1,2,5 in order; key_valid then 0.
4. FIFO full (4 entries); key_read asserted on the same clock a fifth key (code 13) is accepted -> overflow stays 0; reads return the remaining three codes then 13.
5. nRST low for one clock at debounce count 4 -> next clock all outputs are at reset values, ColOut=4'b1110, FIFO empty.
6. KEYPAD_REPEAT_EN defined, key 12 held 80 clocks after acceptance -> pushes at acceptance, +32 and +48, +64 and +80 (FIFO fills; overflow=1 on the 5th push). Macro undefined -> single push, overflow=0.
